// File: rtl/rgb_sram_packer_if.sv
// Pixel stream in, SRAM write port out, for the RGB-to-SRAM packer.
// The packer takes the slave modport; the pixel source and SRAM side take master.
interface rgb_sram_packer_if;
  logic        Start;
  logic [17:0] SRAM_base_address;
  logic        Pixel_valid;
  logic [7:0]  Pixel_R;
  logic [7:0]  Pixel_G;
  logic [7:0]  Pixel_B;
  logic        Pixel_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Done;

  modport slave (
    input  Start, SRAM_base_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B,
    output Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Done
  );

  modport master (
    output Start, SRAM_base_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B,
    input  Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Done
  );
endinterface

// File: rtl/rgb_sram_packer.sv
// Packs 24-bit RGB pixel pairs into three 16-bit SRAM words at consecutive addresses.
// One write per cycle after each accept; Pixel_ready drops while the third word of a pair is written.
module rgb_sram_packer #(
  parameter int PIXEL_COUNT = 76800
) (
  input logic          Clock,
  input logic          Resetn,
  rgb_sram_packer_if.slave bus
);

  localparam int PAIRS = PIXEL_COUNT / 2;
  localparam int CW    = $clog2(PAIRS + 1);
  localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_WRITE_2,
    S_DONE
  } state_t;

  state_t      state;
  logic [17:0] next_addr;
  logic [CW-1:0] pair_cnt;
  logic [7:0]  b0;
  logic [7:0]  g1;
  logic [7:0]  b1;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic        we_n;
  logic        done;
  logic        accept;

  assign bus.Pixel_ready     = (state == S_WAIT_A) || (state == S_WAIT_B);
  assign accept              = bus.Pixel_valid && bus.Pixel_ready;
  assign bus.SRAM_address    = addr;
  assign bus.SRAM_write_data = wdata;
  assign bus.SRAM_we_n       = we_n;
  assign bus.Done            = done;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      next_addr <= '0;
      pair_cnt  <= '0;
      b0        <= '0;
      g1        <= '0;
      b1        <= '0;
      addr      <= '0;
      wdata     <= '0;
      we_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      // Write strobe and Done are single-cycle unless a branch below re-asserts them.
      we_n <= 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            next_addr <= bus.SRAM_base_address;
            pair_cnt  <= '0;
            state     <= S_WAIT_A;
          end
        end
        S_WAIT_A: begin
          if (accept) begin
            addr      <= next_addr;
            wdata     <= {bus.Pixel_R, bus.Pixel_G};
            we_n      <= 1'b0;
            b0        <= bus.Pixel_B;
            next_addr <= next_addr + 18'd1;
            state     <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (accept) begin
            addr      <= next_addr;
            wdata     <= {b0, bus.Pixel_R};
            we_n      <= 1'b0;
            g1        <= bus.Pixel_G;
            b1        <= bus.Pixel_B;
            next_addr <= next_addr + 18'd1;
            state     <= S_WRITE_2;
          end
        end
        S_WRITE_2: begin
          addr      <= next_addr;
          wdata     <= {g1, b1};
          we_n      <= 1'b0;
          next_addr <= next_addr + 18'd1;
          pair_cnt  <= pair_cnt + CW'(1);
          if (pair_cnt == LAST_PAIR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT_A;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_sram_packer.sv
// Directed checks on a two-pixel frame plus a randomly stalled longer frame.
`timescale 1ns/1ps
module tb_rgb_sram_packer;

  localparam int          FRAME_PIXELS = 640;
  localparam logic [17:0] FRAME_BASE   = 18'h3FE80;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  int tests    = 0;
  int fails    = 0;
  int s_done   = 0;
  int f_done   = 0;
  int f_writes = 0;

  wr_t sq[$];
  wr_t fq[$];
  wr_t s_e;
  wr_t f_e;

  rgb_sram_packer_if sb ();
  rgb_sram_packer_if fb ();

  rgb_sram_packer #(.PIXEL_COUNT(2)) u_dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (sb)
  );

  rgb_sram_packer #(.PIXEL_COUNT(FRAME_PIXELS)) u_frame (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (fb)
  );

  always #10 Clock = ~Clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboards: every write strobe must match the head of its queue.
  always @(negedge Clock) begin
    if (sb.SRAM_we_n === 1'b0) begin
      tests++;
      assert (sq.size() != 0) else begin
        fails++;
        $error("FAIL s_unexpected_write: observed %0h@%0h expected none",
               sb.SRAM_write_data, sb.SRAM_address);
      end
      if (sq.size() != 0) begin
        s_e = sq.pop_front();
        chk("s_write", {sb.SRAM_address, sb.SRAM_write_data}, s_e);
      end
    end
    if (sb.Done === 1'b1) s_done++;
  end

  always @(negedge Clock) begin
    if (fb.SRAM_we_n === 1'b0) begin
      f_writes++;
      tests++;
      assert (fq.size() != 0) else begin
        fails++;
        $error("FAIL f_unexpected_write: observed %0h@%0h expected none",
               fb.SRAM_write_data, fb.SRAM_address);
      end
      if (fq.size() != 0) begin
        f_e = fq.pop_front();
        chk("f_write", {fb.SRAM_address, fb.SRAM_write_data}, f_e);
      end
    end
    if (fb.Done === 1'b1) f_done++;
  end

  task automatic s_push(input logic [17:0] a, input logic [7:0] r0, input logic [7:0] g0,
                        input logic [7:0] bl0, input logic [7:0] r1, input logic [7:0] gr1,
                        input logic [7:0] bl1);
    logic [17:0] a1;
    logic [17:0] a2;
    a1 = a + 18'd1;
    a2 = a + 18'd2;
    sq.push_back({a, r0, g0});
    sq.push_back({a1, bl0, r1});
    sq.push_back({a2, gr1, bl1});
  endtask

  task automatic s_start(input logic [17:0] base);
    @(negedge Clock);
    sb.Start             = 1'b1;
    sb.SRAM_base_address = base;
    @(negedge Clock);
    sb.Start             = 1'b0;
  endtask

  task automatic s_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    sb.Pixel_R = r;
    sb.Pixel_G = g;
    sb.Pixel_B = b;
  endtask

  // Entered at a falling edge with the block waiting for the first pixel of a pair.
  task automatic s_pair_held(input logic [17:0] base, input logic [7:0] r0, input logic [7:0] g0,
                             input logic [7:0] bl0, input logic [7:0] r1, input logic [7:0] gr1,
                             input logic [7:0] bl1);
    s_push(base, r0, g0, bl0, r1, gr1, bl1);
    sb.Pixel_valid = 1'b1;
    s_pix(r0, g0, bl0);
    chk("ready_wait_a", 34'(sb.Pixel_ready), 34'd1);
    @(negedge Clock);
    chk("w0_we_n", 34'(sb.SRAM_we_n), 34'd0);
    chk("ready_wait_b", 34'(sb.Pixel_ready), 34'd1);
    s_pix(r1, gr1, bl1);
    @(negedge Clock);
    chk("w1_we_n", 34'(sb.SRAM_we_n), 34'd0);
    chk("ready_write2", 34'(sb.Pixel_ready), 34'd0);
    @(negedge Clock);
    chk("w2_we_n", 34'(sb.SRAM_we_n), 34'd0);
    chk("done_pulse", 34'(sb.Done), 34'd1);
    @(negedge Clock);
    chk("done_single", 34'(sb.Done), 34'd0);
    chk("idle_we_n", 34'(sb.SRAM_we_n), 34'd1);
    chk("ready_idle", 34'(sb.Pixel_ready), 34'd0);
  endtask

  initial begin
    logic        vld;
    logic        acc;
    logic        a1;
    logic        b1;
    logic        b2;
    logic [7:0]  hb0;
    logic [17:0] fa;
    logic [17:0] fa1;
    int          k;
    int          cyc;

    sb.Start = 1'b0; sb.SRAM_base_address = '0; sb.Pixel_valid = 1'b0; s_pix(8'h0, 8'h0, 8'h0);
    fb.Start = 1'b0; fb.SRAM_base_address = '0; fb.Pixel_valid = 1'b0;
    fb.Pixel_R = '0; fb.Pixel_G = '0; fb.Pixel_B = '0;

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_addr",  34'(sb.SRAM_address), 34'd0);
    chk("rst_data",  34'(sb.SRAM_write_data), 34'd0);
    chk("rst_we_n",  34'(sb.SRAM_we_n), 34'd1);
    chk("rst_done",  34'(sb.Done), 34'd0);
    chk("rst_ready", 34'(sb.Pixel_ready), 34'd0);
    Resetn = 1'b1;

    // Pixels offered while idle must not be taken
    sb.Pixel_valid = 1'b1;
    s_pix(8'hAA, 8'hBB, 8'hCC);
    repeat (3) begin
      @(negedge Clock);
      chk("ready_idle_valid", 34'(sb.Pixel_ready), 34'd0);
    end

    // Basic pair with valid held high
    s_start(18'h00100);
    s_pair_held(18'h00100, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    chk("basic_q_empty", 34'(sq.size()), 34'd0);
    chk("basic_done_cnt", 34'(s_done), 34'd1);
    sb.Pixel_valid = 1'b0;

    // Address wrap at the top of the 18-bit space
    s_start(18'h3FFFE);
    s_pair_held(18'h3FFFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    chk("wrap_q_empty", 34'(sq.size()), 34'd0);
    chk("wrap_done_cnt", 34'(s_done), 34'd2);
    sb.Pixel_valid = 1'b0;

    // Start pulsed mid-frame is ignored
    s_start(18'h00200);
    s_push(18'h00200, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60);
    sb.Pixel_valid = 1'b1;
    s_pix(8'h10, 8'h20, 8'h30);
    @(negedge Clock);
    sb.Start = 1'b1;
    sb.SRAM_base_address = 18'h03000;
    s_pix(8'h40, 8'h50, 8'h60);
    @(negedge Clock);
    sb.Start = 1'b0;
    sb.Pixel_valid = 1'b0;
    chk("restart_ready_w2", 34'(sb.Pixel_ready), 34'd0);
    repeat (6) @(negedge Clock);
    chk("restart_q_empty", 34'(sq.size()), 34'd0);
    chk("restart_done_cnt", 34'(s_done), 34'd3);
    chk("restart_idle", 34'(sb.Pixel_ready), 34'd0);

    // Reset after the second word aborts the frame
    s_start(18'h00300);
    sq.push_back({18'h00300, 8'h31, 8'h32});
    sq.push_back({18'h00301, 8'h33, 8'h34});
    sb.Pixel_valid = 1'b1;
    s_pix(8'h31, 8'h32, 8'h33);
    @(negedge Clock);
    s_pix(8'h34, 8'h35, 8'h36);
    @(negedge Clock);
    sb.Pixel_valid = 1'b0;
    #2 Resetn = 1'b0;
    #1;
    chk("abort_addr",  34'(sb.SRAM_address), 34'd0);
    chk("abort_data",  34'(sb.SRAM_write_data), 34'd0);
    chk("abort_we_n",  34'(sb.SRAM_we_n), 34'd1);
    chk("abort_ready", 34'(sb.Pixel_ready), 34'd0);
    chk("abort_done",  34'(sb.Done), 34'd0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    sb.Pixel_valid = 1'b1;
    repeat (3) @(negedge Clock);
    chk("abort_no_done", 34'(s_done), 34'd3);
    chk("abort_q_empty", 34'(sq.size()), 34'd0);
    chk("abort_needs_start", 34'(sb.Pixel_ready), 34'd0);
    s_start(18'h00300);
    s_pair_held(18'h00300, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
    chk("rerun_q_empty", 34'(sq.size()), 34'd0);
    chk("rerun_done_cnt", 34'(s_done), 34'd4);
    sb.Pixel_valid = 1'b0;

    // Longer frame with random stalls; the write strobe is predicted every cycle
    @(negedge Clock);
    fb.Start = 1'b1;
    fb.SRAM_base_address = FRAME_BASE;
    @(negedge Clock);
    fb.Start = 1'b0;
    fa = FRAME_BASE; hb0 = '0;
    a1 = 1'b0; b1 = 1'b0; b2 = 1'b0;
    k = 0; cyc = 0;
    while (k < FRAME_PIXELS && cyc < 20000) begin
      chk("f_we_n", 34'(fb.SRAM_we_n), 34'(!(a1 || b2)));
      vld = ($urandom_range(0, 3) != 0);
      fb.Pixel_valid = vld;
      if (vld) begin
        fb.Pixel_R = 8'($urandom);
        fb.Pixel_G = 8'($urandom);
        fb.Pixel_B = 8'($urandom);
      end
      acc = vld && (fb.Pixel_ready === 1'b1);
      if (acc) begin
        if (k % 2 == 0) begin
          fq.push_back({fa, fb.Pixel_R, fb.Pixel_G});
          hb0 = fb.Pixel_B;
          fa = fa + 18'd1;
        end else begin
          fa1 = fa + 18'd1;
          fq.push_back({fa, hb0, fb.Pixel_R});
          fq.push_back({fa1, fb.Pixel_G, fb.Pixel_B});
          fa = fa + 18'd2;
        end
      end
      b2 = b1;
      b1 = acc && (k % 2 == 1);
      a1 = acc;
      if (acc) k++;
      @(negedge Clock);
      cyc++;
    end
    fb.Pixel_valid = 1'b0;
    repeat (3) begin
      chk("f_we_n_tail", 34'(fb.SRAM_we_n), 34'(!(a1 || b2)));
      b2 = b1; b1 = 1'b0; a1 = 1'b0;
      @(negedge Clock);
    end
    chk("f_pixels_taken", 34'(k), 34'(FRAME_PIXELS));
    chk("f_q_empty", 34'(fq.size()), 34'd0);
    chk("f_write_count", 34'(f_writes), 34'(3 * FRAME_PIXELS / 2));
    chk("f_done_cnt", 34'(f_done), 34'd1);
    chk("f_idle", 34'(fb.Pixel_ready), 34'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
